// File: rtl/rs_driver_if.sv
// Command and latch-side signal bundle for rs_driver.
// The DUT uses the slave modport. The master modport is for the controller,
// which also carries the latch readback lines.
interface rs_driver_if;
    logic REQ;
    logic VAL;
    logic READY;
    logic R;
    logic S;
    logic Q;
    logic Q_B;
    logic DONE;
    logic ERR;

    modport master (
        output REQ,
        output VAL,
        output Q,
        output Q_B,
        input  READY,
        input  R,
        input  S,
        input  DONE,
        input  ERR
    );

    modport slave (
        input  REQ,
        input  VAL,
        input  Q,
        input  Q_B,
        output READY,
        output R,
        output S,
        output DONE,
        output ERR
    );
endinterface

// File: rtl/rs_driver.sv
// rs_driver: turns "set latch to value" requests into single, registered R or S
// pulses of PULSE_W cycles, followed by a GAP_W-cycle recovery gap.
// It then checks the synchronised Q/Q_B readback against the commanded value.
// R and S are never high together. After reset the latch is driven to 0.
module rs_driver #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 2,
    parameter bit          FORCE   = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    rs_driver_if.slave  bus
);

    localparam int unsigned CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_W - 1);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        PULSE,
        GAP,
        CHECK
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] next_cnt;
    logic          cur;
    logic          next_cur;
    logic          shadow;
    logic          next_shadow;
    logic          r_q;
    logic          s_q;
    logic          r_next;
    logic          s_next;
    logic          q_s1;
    logic          q_s2;
    logic          qb_s1;
    logic          qb_s2;
    logic          accept;
    logic          mismatch;

    // Two-flop synchronisers for the asynchronous latch outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_s1  <= 1'b0;
            q_s2  <= 1'b0;
            qb_s1 <= 1'b0;
            qb_s2 <= 1'b0;
        end else begin
            q_s1  <= bus.Q;
            q_s2  <= q_s1;
            qb_s1 <= bus.Q_B;
            qb_s2 <= qb_s1;
        end
    end

    // State, counter, command registers and registered R/S outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= INIT;
            cnt    <= '0;
            cur    <= 1'b0;
            shadow <= 1'b0;
            r_q    <= 1'b0;
            s_q    <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= next_cnt;
            cur    <= next_cur;
            shadow <= next_shadow;
            r_q    <= r_next;
            s_q    <= s_next;
        end
    end

    assign accept = (state == IDLE) && bus.REQ;

    // Next-state, counter and command decode.
    // In INIT the count only starts once R is visibly high. This gives the
    // first post-reset cycle a full PULSE_W-wide R pulse, even though the
    // state register already holds INIT during reset.
    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        next_cur    = cur;
        next_shadow = shadow;
        unique case (state)
            INIT: begin
                next_cur = 1'b0;
                if (r_q) begin
                    if (cnt == PULSE_LAST) begin
                        next_state = GAP;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt + CW'(1);
                    end
                end
            end
            IDLE: begin
                if (accept) begin
                    next_cur    = bus.VAL;
                    next_shadow = bus.VAL;
                    next_cnt    = '0;
                    if ((bus.VAL != shadow) || FORCE) begin
                        next_state = PULSE;
                    end else begin
                        next_state = CHECK;
                    end
                end
            end
            PULSE: begin
                if (cnt == PULSE_LAST) begin
                    next_state = GAP;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CW'(1);
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    next_state = CHECK;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CW'(1);
                end
            end
            CHECK: begin
                next_state = IDLE;
            end
            default: begin
                next_state = INIT;
                next_cnt   = '0;
            end
        endcase
    end

    // R/S are decoded from the next state and registered, so they are
    // glitch-free and cannot overlap.
    always_comb begin
        r_next = 1'b0;
        s_next = 1'b0;
        if (next_state == INIT) begin
            r_next = 1'b1;
        end else if (next_state == PULSE) begin
            r_next = ~next_cur;
            s_next = next_cur;
        end
    end

    assign mismatch  = (q_s2 != cur) || (qb_s2 != ~cur);

    assign bus.R     = r_q;
    assign bus.S     = s_q;
    assign bus.READY = (state == IDLE);
    assign bus.DONE  = (state == CHECK);
    assign bus.ERR   = (state == CHECK) && mismatch;

endmodule

// File: tb/tb_rs_driver.sv
// Directed and random checks for rs_driver. Each DUT instance drives an
// ideal RS latch model, and u0's latch model can be forced into fault modes.
module tb_rs_driver;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rst0;
    logic rst1;
    logic rst2;
    logic [1:0] fault0;

    int checks   = 0;
    int failures = 0;

    rs_driver_if bus0 ();
    rs_driver_if bus1 ();
    rs_driver_if bus2 ();

    rs_driver #(.PULSE_W(2), .GAP_W(2), .FORCE(1'b0)) u0 (.CLK(CLK), .RST(rst0), .bus(bus0));
    rs_driver #(.PULSE_W(2), .GAP_W(2), .FORCE(1'b1)) u1 (.CLK(CLK), .RST(rst1), .bus(bus1));
    rs_driver #(.PULSE_W(3), .GAP_W(4), .FORCE(1'b0)) u2 (.CLK(CLK), .RST(rst2), .bus(bus2));

    // Ideal latch models, starting at 1 so the INIT pulse has something to clear.
    logic lq0 = 1'b1;
    logic lq1 = 1'b1;
    logic lq2 = 1'b1;

    always @(bus0.R or bus0.S) begin
        if (bus0.S === 1'b1 && bus0.R !== 1'b1) lq0 = 1'b1;
        else if (bus0.R === 1'b1 && bus0.S !== 1'b1) lq0 = 1'b0;
    end
    always @(bus1.R or bus1.S) begin
        if (bus1.S === 1'b1 && bus1.R !== 1'b1) lq1 = 1'b1;
        else if (bus1.R === 1'b1 && bus1.S !== 1'b1) lq1 = 1'b0;
    end
    always @(bus2.R or bus2.S) begin
        if (bus2.S === 1'b1 && bus2.R !== 1'b1) lq2 = 1'b1;
        else if (bus2.R === 1'b1 && bus2.S !== 1'b1) lq2 = 1'b0;
    end

    // fault0: 0 = ideal, 1 = Q stuck 0 / Q_B stuck 1, 2 = Q and Q_B both 0.
    assign bus0.Q   = (fault0 != 2'd0) ? 1'b0 : lq0;
    assign bus0.Q_B = (fault0 == 2'd1) ? 1'b1 : (fault0 == 2'd2) ? 1'b0 : ~lq0;
    assign bus1.Q   = lq1;
    assign bus1.Q_B = ~lq1;
    assign bus2.Q   = lq2;
    assign bus2.Q_B = ~lq2;

    // Watchdog: the bench must always terminate.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Vector order everywhere: {R,S,DONE,ERR,READY}.
    task automatic test_reset;
        logic [5:0] er, ed, ey;
        logic [4:0] got, exp;
        er = 6'b000011; ed = 6'b010000; ey = 6'b100000;
        rst0 = 1'b1;
        bus0.REQ = 1'b0;
        bus0.VAL = 1'b0;
        fault0 = 2'd0;
        repeat (3) begin
            @(negedge CLK);
            got = {bus0.R, bus0.S, bus0.DONE, bus0.ERR, bus0.READY};
            checks++;
            if (got !== 5'b0) begin
                failures++;
                $display("FAIL reset_hold got=%b exp=00000", got);
            end
        end
        rst0 = 1'b0;
        @(posedge CLK);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            got = {bus0.R, bus0.S, bus0.DONE, bus0.ERR, bus0.READY};
            exp = {er[i], 1'b0, ed[i], 1'b0, ey[i]};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL init_seq cycle=%0d got=%b exp=%b", i + 1, got, exp);
            end
        end
    endtask

    task automatic test_set;
        logic [5:0] es, ed, ey;
        logic [4:0] got, exp;
        es = 6'b000011; ed = 6'b010000; ey = 6'b100000;
        bus0.REQ = 1'b1;
        bus0.VAL = 1'b1;
        @(posedge CLK);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (i == 0) bus0.REQ = 1'b0;
            got = {bus0.R, bus0.S, bus0.DONE, bus0.ERR, bus0.READY};
            exp = {1'b0, es[i], ed[i], 1'b0, ey[i]};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL set_cmd cycle=%0d got=%b exp=%b", i + 1, got, exp);
            end
        end
    endtask

    task automatic test_skip;
        logic [4:0] got;
        bus0.REQ = 1'b1;
        bus0.VAL = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus0.REQ = 1'b0;
        got = {bus0.R, bus0.S, bus0.DONE, bus0.ERR, bus0.READY};
        checks++;
        if (got !== 5'b00100) begin
            failures++;
            $display("FAIL skip_done got=%b exp=00100", got);
        end
        @(negedge CLK);
        got = {bus0.R, bus0.S, bus0.DONE, bus0.ERR, bus0.READY};
        checks++;
        if (got !== 5'b00001) begin
            failures++;
            $display("FAIL skip_ready got=%b exp=00001", got);
        end
    endtask

    task automatic test_force;
        logic [5:0] es, ed, ey;
        logic [4:0] got, exp;
        int n;
        es = 6'b000011; ed = 6'b010000; ey = 6'b100000;
        bus1.REQ = 1'b0;
        bus1.VAL = 1'b0;
        @(negedge CLK);
        rst1 = 1'b0;
        n = 0;
        do begin @(negedge CLK); n++; end while (bus1.READY !== 1'b1 && n < 20);
        checks++;
        if (bus1.READY !== 1'b1) begin
            failures++;
            $display("FAIL force_init_ready got=%b exp=1", bus1.READY);
        end
        bus1.REQ = 1'b1;
        bus1.VAL = 1'b1;
        @(posedge CLK);
        n = 0;
        do begin @(negedge CLK); bus1.REQ = 1'b0; n++; end while (bus1.READY !== 1'b1 && n < 20);
        checks++;
        if (bus1.READY !== 1'b1) begin
            failures++;
            $display("FAIL force_first_ready got=%b exp=1", bus1.READY);
        end
        // Same value again: FORCE=1 must still pulse S.
        bus1.REQ = 1'b1;
        bus1.VAL = 1'b1;
        @(posedge CLK);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (i == 0) bus1.REQ = 1'b0;
            got = {bus1.R, bus1.S, bus1.DONE, bus1.ERR, bus1.READY};
            exp = {1'b0, es[i], ed[i], 1'b0, ey[i]};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL force_repeat cycle=%0d got=%b exp=%b", i + 1, got, exp);
            end
        end
    endtask

    task automatic test_fault;
        logic [1:0] mode [3];
        logic       val  [3];
        logic       eerr [3];
        logic [5:0] ep, ed, ey;
        logic [4:0] got, exp;
        mode[0] = 2'd0; val[0] = 1'b0; eerr[0] = 1'b0;
        mode[1] = 2'd1; val[1] = 1'b1; eerr[1] = 1'b1;
        mode[2] = 2'd2; val[2] = 1'b0; eerr[2] = 1'b1;
        ep = 6'b000011; ed = 6'b010000; ey = 6'b100000;
        for (int c = 0; c < 3; c++) begin
            fault0   = mode[c];
            bus0.REQ = 1'b1;
            bus0.VAL = val[c];
            @(posedge CLK);
            for (int i = 0; i < 6; i++) begin
                @(negedge CLK);
                if (i == 0) bus0.REQ = 1'b0;
                got = {bus0.R, bus0.S, bus0.DONE, bus0.ERR, bus0.READY};
                exp = {ep[i] & ~val[c], ep[i] & val[c], ed[i], ed[i] & eerr[c], ey[i]};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL fault_mode%0d cycle=%0d got=%b exp=%b", mode[c], i + 1, got, exp);
                end
            end
        end
        fault0 = 2'd0;
    endtask

    task automatic test_ignored;
        int dones, s_cyc, r_cyc;
        dones = 0; s_cyc = 0; r_cyc = 0;
        bus0.REQ = 1'b1;
        bus0.VAL = 1'b1;
        @(posedge CLK);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (bus0.DONE === 1'b1) dones++;
            if (bus0.S === 1'b1) s_cyc++;
            if (bus0.R === 1'b1) r_cyc++;
            if (i == 2) bus0.VAL = 1'b0;
            if (i == 5) bus0.REQ = 1'b0;
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL ignored_dones got=%0d exp=1", dones);
        end
        checks++;
        if (s_cyc != 2 || r_cyc != 0) begin
            failures++;
            $display("FAIL ignored_pulses got=s%0d_r%0d exp=s2_r0", s_cyc, r_cyc);
        end
    endtask

    task automatic test_reset_mid;
        logic [5:0] er, ed, ey;
        logic [4:0] got, exp;
        er = 6'b000011; ed = 6'b010000; ey = 6'b100000;
        bus0.REQ = 1'b1;
        bus0.VAL = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        bus0.REQ = 1'b0;
        checks++;
        if (bus0.R !== 1'b1) begin
            failures++;
            $display("FAIL mid_pulse_r got=%b exp=1", bus0.R);
        end
        rst0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            got = {bus0.R, bus0.S, bus0.DONE, bus0.ERR, bus0.READY};
            checks++;
            if (got !== 5'b0) begin
                failures++;
                $display("FAIL mid_reset cycle=%0d got=%b exp=00000", i + 1, got);
            end
        end
        rst0 = 1'b0;
        @(posedge CLK);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            got = {bus0.R, bus0.S, bus0.DONE, bus0.ERR, bus0.READY};
            exp = {er[i], 1'b0, ed[i], 1'b0, ey[i]};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL mid_init_replay cycle=%0d got=%b exp=%b", i + 1, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [17:0] er, es, ed, ey;
        logic [4:0]  got, exp;
        es = 18'b000011000000000011;
        er = 18'b000000000011000000;
        ed = 18'b010000010000010000;
        ey = 18'b100000100000100000;
        bus0.REQ = 1'b1;
        bus0.VAL = 1'b1;
        @(posedge CLK);
        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            got = {bus0.R, bus0.S, bus0.DONE, bus0.ERR, bus0.READY};
            exp = {er[i], es[i], ed[i], 1'b0, ey[i]};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL back_to_back cycle=%0d got=%b exp=%b", i + 1, got, exp);
            end
            if (bus0.READY === 1'b1) bus0.VAL = ~bus0.VAL;
            if (i == 17) bus0.REQ = 1'b0;
        end
    endtask

    task automatic test_stress;
        int         run, dones;
        logic [5:0] rs_h, rst_h;
        logic       rs, prev_ready, prev_req, ok;
        run = 0; dones = 0;
        rs_h = '0; rst_h = '1;
        prev_ready = 1'b0; prev_req = 1'b0;
        bus2.REQ = 1'b0;
        bus2.VAL = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge CLK);
            rs = bus2.R | bus2.S;
            checks++;
            if ((bus2.R & bus2.S) !== 1'b0) begin
                failures++;
                $display("FAIL stress_rs_overlap cycle=%0d got=%b%b exp=not11", n, bus2.R, bus2.S);
            end
            if (rs) begin
                run++;
            end else if (run > 0) begin
                if (!rst_h[0]) begin
                    checks++;
                    if (run != 3) begin
                        failures++;
                        $display("FAIL stress_pulse_width cycle=%0d got=%0d exp=3", n, run);
                    end
                end
                run = 0;
            end
            if (bus2.DONE === 1'b1) begin
                dones++;
                ok = !rst_h[0] && ((prev_ready && prev_req) ||
                     (rs_h[3:0] == 4'b0 && rs_h[4] && rst_h[4:0] == 5'b0));
                checks++;
                if (!ok) begin
                    failures++;
                    $display("FAIL stress_done_context cycle=%0d got=rs%b_rst%b exp=check", n, rs_h, rst_h);
                end
                checks++;
                if (bus2.ERR !== 1'b0) begin
                    failures++;
                    $display("FAIL stress_err cycle=%0d got=%b exp=0", n, bus2.ERR);
                end
            end
            checks++;
            if (bus2.READY === 1'b1 && (rs || bus2.DONE === 1'b1)) begin
                failures++;
                $display("FAIL stress_ready_excl cycle=%0d got=%b%b exp=idle", n, rs, bus2.DONE);
            end
            rs_h       = {rs_h[4:0], rs};
            prev_ready = bus2.READY;
            rst2       = ($urandom_range(0, 99) < 2);
            bus2.REQ   = 1'($urandom_range(0, 1));
            bus2.VAL   = 1'($urandom_range(0, 1));
            prev_req   = bus2.REQ;
            rst_h      = {rst_h[4:0], rst2};
        end
        checks++;
        if (dones < 20) begin
            failures++;
            $display("FAIL stress_activity got=%0d exp=>=20", dones);
        end
    endtask

    initial begin
        rst1 = 1'b1;
        rst2 = 1'b1;
        bus1.REQ = 1'b0;
        bus1.VAL = 1'b0;
        bus2.REQ = 1'b0;
        bus2.VAL = 1'b0;
        test_reset();
        test_set();
        test_skip();
        test_force();
        test_fault();
        test_ignored();
        test_reset_mid();
        test_back_to_back();
        test_stress();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
